// File: rtl/fp_arith_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fp_arith_unit_if                                          |
// | Brief    : Start/operand/result bundle for the single-precision core |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface fp_arith_unit_if;
  logic        en;      // start strobe
  logic [1:0]  op;      // 00 add, 01 sub, 10 mul, 11 div
  logic [31:0] in_a;    // operand A
  logic [31:0] in_b;    // operand B
  logic [31:0] result;  // last completed result
  logic        finish;  // one-cycle completion pulse
  logic        busy;    // divide in progress

  modport master (
    output en, op, in_a, in_b,
    input  result, finish, busy
  );

  modport slave (
    input  en, op, in_a, in_b,
    output result, finish, busy
  );
endinterface
`default_nettype wire

// File: rtl/fp_arith_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fp_arith_unit                                             |
// | Brief    : IEEE-754 single add/sub/mul (1 cycle) and iterative div   |
// |            with round-to-nearest-even and denormal flush-to-zero.    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module fp_arith_unit #(
  // Quotient register is sized for 26 bits (24 + guard + round), which is
  // what 1 setup bit plus DIV_CYCLES-1 iterations produce at the default.
  parameter int DIV_CYCLES = 26
) (
  input  logic           clk,
  input  logic           rst,
  fp_arith_unit_if.slave bus
);

  localparam int               CNT_W      = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(DIV_CYCLES - 1);
  localparam logic [31:0]      c_qnan     = 32'h7FC0_0000;
  localparam logic [1:0]       c_op_add   = 2'b00;
  localparam logic [1:0]       c_op_sub   = 2'b01;
  localparam logic [1:0]       c_op_mul   = 2'b10;
  localparam logic [1:0]       c_op_div   = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_DIV  = 1'b1
  } state_t;

  // ---------------- field helpers ----------------
  function automatic logic f_is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic f_is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
  endfunction

  // Denormals count as zero because they are flushed on input.
  function automatic logic f_is_zero(input logic [31:0] x);
    return (x[30:23] == 8'h00);
  endfunction

  function automatic logic [23:0] f_mant(input logic [31:0] x);
    return (x[30:23] == 8'h00) ? 24'd0 : {1'b1, x[22:0]};
  endfunction

  function automatic logic [4:0] f_lzc(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + 5'd1;
      end
    end
    return n;
  endfunction

  // Round-to-nearest-even on a normalised 24-bit significand, then pack
  // with overflow to infinity and underflow flushed to signed zero.
  function automatic logic [31:0] f_round_pack(input logic sgn, input logic signed [11:0] exp_in,
                                               input logic [23:0] man, input logic g, input logic s);
    logic [24:0]        m25;
    logic signed [11:0] e;
    m25 = {1'b0, man} + {24'd0, g & (s | man[0])};
    e   = exp_in;
    if (m25[24]) begin
      e   = e + 12'sd1;
      m25 = m25 >> 1;
    end
    if (e >= 12'sd255) return {sgn, 8'hFF, 23'd0};
    if (e <= 12'sd0)   return {sgn, 31'd0};
    return {sgn, e[7:0], m25[22:0]};
  endfunction

  function automatic logic [31:0] f_addsub(input logic [31:0] a, input logic [31:0] b,
                                           input logic do_sub);
    logic               sa, sb, sg;
    logic [7:0]         eg, el, d;
    logic [23:0]        mg, ml;
    logic [26:0]        sm, sh, al, bg, diff, norm;
    logic [27:0]        sum;
    logic               sticky;
    logic signed [11:0] e;
    sa = a[31];
    sb = b[31] ^ do_sub;
    if (f_is_nan(a) || f_is_nan(b)) return c_qnan;
    if (f_is_inf(a) && f_is_inf(b)) return (sa == sb) ? {sa, 8'hFF, 23'd0} : c_qnan;
    if (f_is_inf(a)) return {sa, 8'hFF, 23'd0};
    if (f_is_inf(b)) return {sb, 8'hFF, 23'd0};
    if ({a[30:23], f_mant(a)} >= {b[30:23], f_mant(b)}) begin
      sg = sa; eg = a[30:23]; mg = f_mant(a); el = b[30:23]; ml = f_mant(b);
    end else begin
      sg = sb; eg = b[30:23]; mg = f_mant(b); el = a[30:23]; ml = f_mant(a);
    end
    // Align the smaller operand, folding shifted-out bits into sticky.
    d      = eg - el;
    sm     = {ml, 3'b000};
    sh     = sm >> d;
    sticky = ((sh << d) != sm);
    al     = sh | {26'd0, sticky};
    bg     = {mg, 3'b000};
    e      = $signed({4'd0, eg});
    if (sa == sb) begin
      sum = {1'b0, bg} + {1'b0, al};
      if (sum == 28'd0) return {sg, 31'd0};
      if (sum[27]) begin
        norm = sum[27:1] | {26'd0, sum[0]};
        e    = e + 12'sd1;
      end else begin
        norm = sum[26:0];
      end
    end else begin
      diff = bg - al;
      if (diff == 27'd0) return 32'd0;   // exact cancellation is +0
      norm = diff << f_lzc(diff);
      e    = e - $signed({7'd0, f_lzc(diff)});
    end
    return f_round_pack(sg, e, norm[26:3], norm[2], |norm[1:0]);
  endfunction

  function automatic logic [31:0] f_mul(input logic [31:0] a, input logic [31:0] b);
    logic               s;
    logic [47:0]        p;
    logic signed [11:0] e;
    s = a[31] ^ b[31];
    if (f_is_nan(a) || f_is_nan(b)) return c_qnan;
    if ((f_is_inf(a) && f_is_zero(b)) || (f_is_zero(a) && f_is_inf(b))) return c_qnan;
    if (f_is_inf(a) || f_is_inf(b))   return {s, 8'hFF, 23'd0};
    if (f_is_zero(a) || f_is_zero(b)) return {s, 31'd0};
    p = {24'd0, f_mant(a)} * {24'd0, f_mant(b)};
    e = $signed({4'd0, a[30:23]}) + $signed({4'd0, b[30:23]}) - 12'sd127;
    if (p[47]) return f_round_pack(s, e + 12'sd1, p[47:24], p[23], |p[22:0]);
    return f_round_pack(s, e, p[46:23], p[22], |p[21:0]);
  endfunction

  // ---------------- state ----------------
  state_t             state_q,    state_d;
  logic [31:0]        result_q,   result_d;
  logic               finish_q,   finish_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic [25:0]        quo_q,      quo_d;
  logic [23:0]        rem_q,      rem_d;
  logic [23:0]        dvs_q,      dvs_d;
  logic               sign_q,     sign_d;
  logic signed [11:0] exp_q,      exp_d;
  logic               spec_q,     spec_d;
  logic [31:0]        spec_val_q, spec_val_d;

  logic [31:0]        w_fast_res;
  logic [23:0]        w_dv_ma, w_dv_mb, w_dv_rem;
  logic               w_dv_lt, w_dv_sign, w_dv_spec;
  logic [24:0]        w_dv_num;
  logic signed [11:0] w_dv_exp;
  logic [31:0]        w_dv_val;
  logic [24:0]        w_it_r2;
  logic               w_it_ge;
  logic [23:0]        w_it_rem;

  // Single-cycle result for add/sub/mul from the live operands.
  always_comb begin
    w_fast_res = f_mul(bus.in_a, bus.in_b);
    case (bus.op)
      c_op_add: w_fast_res = f_addsub(bus.in_a, bus.in_b, 1'b0);
      c_op_sub: w_fast_res = f_addsub(bus.in_a, bus.in_b, 1'b1);
      default:  w_fast_res = f_mul(bus.in_a, bus.in_b);
    endcase
  end

  // Divide setup: pre-normalise so the quotient lies in [1,2) and its
  // leading 1 is produced at acceptance; also resolve special operands.
  always_comb begin
    w_dv_ma   = f_mant(bus.in_a);
    w_dv_mb   = f_mant(bus.in_b);
    w_dv_sign = bus.in_a[31] ^ bus.in_b[31];
    w_dv_lt   = (w_dv_ma < w_dv_mb);
    w_dv_num  = w_dv_lt ? {w_dv_ma, 1'b0} : {1'b0, w_dv_ma};
    w_dv_rem  = 24'(w_dv_num - {1'b0, w_dv_mb});
    w_dv_exp  = $signed({4'd0, bus.in_a[30:23]}) - $signed({4'd0, bus.in_b[30:23]})
              + 12'sd127 - (w_dv_lt ? 12'sd1 : 12'sd0);
    w_dv_spec = 1'b1;
    w_dv_val  = c_qnan;
    if (f_is_nan(bus.in_a) || f_is_nan(bus.in_b) ||
        (f_is_zero(bus.in_a) && f_is_zero(bus.in_b)) ||
        (f_is_inf(bus.in_a) && f_is_inf(bus.in_b))) begin
      w_dv_val = c_qnan;
    end else if (f_is_inf(bus.in_a) || f_is_zero(bus.in_b)) begin
      w_dv_val = {w_dv_sign, 8'hFF, 23'd0};
    end else if (f_is_inf(bus.in_b) || f_is_zero(bus.in_a)) begin
      w_dv_val = {w_dv_sign, 31'd0};
    end else begin
      w_dv_spec = 1'b0;
    end
  end

  // One restoring-division step: shift remainder, subtract divisor if it fits.
  always_comb begin
    w_it_r2  = {rem_q, 1'b0};
    w_it_ge  = (w_it_r2 >= {1'b0, dvs_q});
    w_it_rem = w_it_ge ? 24'(w_it_r2 - {1'b0, dvs_q}) : w_it_r2[23:0];
  end

  // Next-state: accept in idle, iterate while dividing, publish on the last count.
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    finish_d   = 1'b0;
    cnt_d      = cnt_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    dvs_d      = dvs_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    spec_d     = spec_q;
    spec_val_d = spec_val_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.en) begin
          if (bus.op == c_op_div) begin
            state_d    = ST_DIV;
            cnt_d      = c_cnt_load;
            quo_d      = 26'd1;
            rem_d      = w_dv_rem;
            dvs_d      = w_dv_mb;
            sign_d     = w_dv_sign;
            exp_d      = w_dv_exp;
            spec_d     = w_dv_spec;
            spec_val_d = w_dv_val;
          end else begin
            result_d = w_fast_res;
            finish_d = 1'b1;
          end
        end
      end
      ST_DIV: begin
        if (cnt_q == '0) begin
          result_d = spec_q ? spec_val_q
                   : f_round_pack(sign_q, exp_q, quo_q[25:2], quo_q[1], quo_q[0] | (|rem_q));
          finish_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          quo_d = {quo_q[24:0], w_it_ge};
          rem_d = w_it_rem;
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset aborts any divide without a finish pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      result_q   <= 32'd0;
      finish_q   <= 1'b0;
      cnt_q      <= '0;
      quo_q      <= 26'd0;
      rem_q      <= 24'd0;
      dvs_q      <= 24'd0;
      sign_q     <= 1'b0;
      exp_q      <= 12'sd0;
      spec_q     <= 1'b0;
      spec_val_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      finish_q   <= finish_d;
      cnt_q      <= cnt_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      dvs_q      <= dvs_d;
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      spec_q     <= spec_d;
      spec_val_q <= spec_val_d;
    end
  end

  assign bus.result = result_q;
  assign bus.finish = finish_q;
  assign bus.busy   = (state_q == ST_DIV);

endmodule
`default_nettype wire

// File: tb/tb_fp_arith_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_fp_arith_unit                                          |
// | Brief    : Directed-vector bench for fp_arith_unit                   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_fp_arith_unit;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  fp_arith_unit_if bus ();

  fp_arith_unit #(.DIV_CYCLES(26)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operation for a single edge, then scramble the operands.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.en   = 1'b1;
    bus.op   = o;
    bus.in_a = a;
    bus.in_b = b;
    @(posedge clk);
    #1;
    bus.en   = 1'b0;
    bus.op   = 2'b00;
    bus.in_a = 32'hDEAD_BEEF;
    bus.in_b = 32'h1234_5678;
  endtask

  // Count edges until finish (bounded), noting whether busy ever dropped early.
  task automatic wait_finish(output int n, output logic busy_ok);
    n       = 0;
    busy_ok = 1'b1;
    while (n < 60) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.finish) break;
      if (!bus.busy) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bus.result !== 32'd0 || bus.finish !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset: result=%h finish=%b busy=%b expected 00000000 0 0",
               bus.result, bus.finish, bus.busy);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add();
    logic [31:0] va [8];
    logic [31:0] vb [8];
    logic [31:0] vr [8];
    va = '{32'h3F800000, 32'h3FC00000, 32'hBF800000, 32'h3F800000,
           32'h3F800001, 32'h7F7FFFFF, 32'h7FC00001, 32'h00000001};
    vb = '{32'h40000000, 32'h40200000, 32'h3F800000, 32'h33800000,
           32'h33800000, 32'h7F7FFFFF, 32'h3F800000, 32'h3F800000};
    vr = '{32'h40400000, 32'h40800000, 32'h00000000, 32'h3F800000,
           32'h3F800002, 32'h7F800000, 32'h7FC00000, 32'h3F800000};
    for (int i = 0; i < 8; i++) begin
      issue(2'b00, va[i], vb[i]);
      total++;
      if (bus.result !== vr[i] || bus.finish !== 1'b1) begin
        bad++;
        $display("FAIL add[%0d]: result=%h finish=%b expected %h 1", i, bus.result, bus.finish, vr[i]);
      end
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.finish !== 1'b0 || bus.result !== 32'h3F800000) begin
      bad++;
      $display("FAIL add_hold: result=%h finish=%b expected 3f800000 0", bus.result, bus.finish);
    end
  endtask

  task automatic test_sub();
    logic [31:0] va [5];
    logic [31:0] vb [5];
    logic [31:0] vr [5];
    va = '{32'h40400000, 32'h40400000, 32'h7F800000, 32'h3F800000, 32'hC0000000};
    vb = '{32'h40A00000, 32'h40400000, 32'h7F800000, 32'hBF800000, 32'hC0000000};
    vr = '{32'hC0000000, 32'h00000000, 32'h7FC00000, 32'h40000000, 32'h00000000};
    for (int i = 0; i < 5; i++) begin
      issue(2'b01, va[i], vb[i]);
      total++;
      if (bus.result !== vr[i] || bus.finish !== 1'b1) begin
        bad++;
        $display("FAIL sub[%0d]: result=%h finish=%b expected %h 1", i, bus.result, bus.finish, vr[i]);
      end
    end
  endtask

  task automatic test_mul();
    logic [31:0] va [7];
    logic [31:0] vb [7];
    logic [31:0] vr [7];
    va = '{32'h3FC00000, 32'h7F7FFFFF, 32'hC0000000, 32'h00000000,
           32'h00800000, 32'h80000000, 32'h3F800001};
    vb = '{32'h40200000, 32'h40000000, 32'h40400000, 32'h7F800000,
           32'h00800000, 32'h3F800000, 32'h3F800001};
    vr = '{32'h40700000, 32'h7F800000, 32'hC0C00000, 32'h7FC00000,
           32'h00000000, 32'h80000000, 32'h3F800002};
    for (int i = 0; i < 7; i++) begin
      issue(2'b10, va[i], vb[i]);
      total++;
      if (bus.result !== vr[i] || bus.finish !== 1'b1) begin
        bad++;
        $display("FAIL mul[%0d]: result=%h finish=%b expected %h 1", i, bus.result, bus.finish, vr[i]);
      end
    end
  endtask

  task automatic test_div();
    logic [31:0] va [5];
    logic [31:0] vb [5];
    logic [31:0] vr [5];
    int          n;
    logic        bok;
    va = '{32'h3F800000, 32'h40C00000, 32'h3F800000, 32'h00000000, 32'hBF800000};
    vb = '{32'h40400000, 32'h40000000, 32'h00000000, 32'h00000000, 32'h7F800000};
    vr = '{32'h3EAAAAAB, 32'h40400000, 32'h7F800000, 32'h7FC00000, 32'h80000000};
    for (int i = 0; i < 5; i++) begin
      issue(2'b11, va[i], vb[i]);
      total++;
      if (bus.busy !== 1'b1 || bus.finish !== 1'b0) begin
        bad++;
        $display("FAIL div_accept[%0d]: busy=%b finish=%b expected 1 0", i, bus.busy, bus.finish);
      end
      wait_finish(n, bok);
      total++;
      if (n != 26 || bok !== 1'b1 || bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL div_timing[%0d]: cycles=%0d busy_held=%b busy_at_finish=%b expected 26 1 0",
                 i, n, bok, bus.busy);
      end
      total++;
      if (bus.result !== vr[i] || bus.finish !== 1'b1) begin
        bad++;
        $display("FAIL div[%0d]: result=%h finish=%b expected %h 1", i, bus.result, bus.finish, vr[i]);
      end
    end
  endtask

  task automatic test_en_ignored();
    int   n;
    logic bok;
    logic early;
    early = 1'b0;
    issue(2'b11, 32'h3F800000, 32'h40400000);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.en   = 1'b1;
      bus.op   = 2'b00;
      bus.in_a = 32'h3F800000;
      bus.in_b = 32'h3F800000;
      @(posedge clk);
      #1;
      bus.en = 1'b0;
      if (bus.finish !== 1'b0) early = 1'b1;
    end
    total++;
    if (early !== 1'b0) begin
      bad++;
      $display("FAIL en_ignored_finish: early finish seen=%b expected 0", early);
    end
    wait_finish(n, bok);
    total++;
    if (n + 5 != 26 || bus.result !== 32'h3EAAAAAB) begin
      bad++;
      $display("FAIL en_ignored_div: cycles=%0d result=%h expected 26 3eaaaaab", n + 5, bus.result);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.finish !== 1'b0 || bus.result !== 32'h3EAAAAAB) begin
      bad++;
      $display("FAIL en_ignored_after: finish=%b result=%h expected 0 3eaaaaab", bus.finish, bus.result);
    end
  endtask

  task automatic test_reset_mid_div();
    logic saw;
    saw = 1'b0;
    issue(2'b11, 32'h40C00000, 32'h40000000);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (bus.result !== 32'd0 || bus.busy !== 1'b0 || bus.finish !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_div: result=%h busy=%b finish=%b expected 00000000 0 0",
               bus.result, bus.busy, bus.finish);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (bus.finish !== 1'b0 || bus.busy !== 1'b0) saw = 1'b1;
    end
    total++;
    if (saw !== 1'b0) begin
      bad++;
      $display("FAIL reset_abort: stray finish/busy seen=%b expected 0", saw);
    end
  endtask

  task automatic test_back_to_back();
    int   n;
    logic bok;
    issue(2'b00, 32'h3F800000, 32'h40000000);
    total++;
    if (bus.result !== 32'h40400000 || bus.finish !== 1'b1) begin
      bad++;
      $display("FAIL b2b_add: result=%h finish=%b expected 40400000 1", bus.result, bus.finish);
    end
    issue(2'b10, 32'h3FC00000, 32'h40200000);
    total++;
    if (bus.result !== 32'h40700000 || bus.finish !== 1'b1) begin
      bad++;
      $display("FAIL b2b_mul: result=%h finish=%b expected 40700000 1", bus.result, bus.finish);
    end
    issue(2'b01, 32'h40400000, 32'h40A00000);
    total++;
    if (bus.result !== 32'hC0000000 || bus.finish !== 1'b1) begin
      bad++;
      $display("FAIL b2b_sub: result=%h finish=%b expected c0000000 1", bus.result, bus.finish);
    end
    issue(2'b11, 32'h40C00000, 32'h40000000);
    wait_finish(n, bok);
    total++;
    if (n != 26 || bus.result !== 32'h40400000) begin
      bad++;
      $display("FAIL b2b_div: cycles=%0d result=%h expected 26 40400000", n, bus.result);
    end
    // Accepted on the edge that ends the divide's finish pulse.
    issue(2'b00, 32'h3FC00000, 32'h40200000);
    total++;
    if (bus.result !== 32'h40800000 || bus.finish !== 1'b1 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_after_div: result=%h finish=%b busy=%b expected 40800000 1 0",
               bus.result, bus.finish, bus.busy);
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    bus.en   = 1'b0;
    bus.op   = 2'b00;
    bus.in_a = 32'd0;
    bus.in_b = 32'd0;
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_div();
    test_en_ignored();
    test_reset_mid_div();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
